rgb2ycbcr: RTL



---
 rtl/rgb2ycbcr_pkg.sv | 41 ++++
 rtl/rgb2ycbcr_sync.sv | 34 +++
 rtl/rgb2ycbcr.sv | 97 +++++++++
 3 files changed

// File: rtl/rgb2ycbcr_pkg.sv
// Shared types, BT.601 coefficients and the rounding/clamp helper for rgb2ycbcr.
// Optional build macro: RGB2YCBCR_ROUND_EN (round half up instead of truncating).
package rgb2ycbcr_pkg;

    typedef logic [7:0]         pix_t;
    typedef logic signed [17:0] psum_t;

    // Coefficients, scaled by 256
    localparam logic [15:0] C_Y_R  = 16'd77;
    localparam logic [15:0] C_Y_G  = 16'd150;
    localparam logic [15:0] C_Y_B  = 16'd29;
    localparam logic [15:0] C_CB_R = 16'd43;
    localparam logic [15:0] C_CB_G = 16'd85;
    localparam logic [15:0] C_CB_B = 16'd128;
    localparam logic [15:0] C_CR_R = 16'd128;
    localparam logic [15:0] C_CR_G = 16'd107;
    localparam logic [15:0] C_CR_B = 16'd21;

    localparam logic [17:0] OFFSET_C = 18'd32768;
    localparam int          SHIFT    = 8;

`ifdef RGB2YCBCR_ROUND_EN
    localparam logic signed [19:0] RND = 20'sd128;
`else
    localparam logic signed [19:0] RND = 20'sd0;
`endif

    // Scale a weighted sum back to 8 bits and saturate to [0,255].
    function automatic pix_t round_clamp(input psum_t s);
        logic signed [19:0] t;
        t = {{2{s[17]}}, s} + RND;
        t = t >>> SHIFT;
        if (t < 20'sd0)
            return 8'd0;
        else if (t > 20'sd255)
            return 8'd255;
        else
            return t[7:0];
    endfunction

endpackage

// File: rtl/rgb2ycbcr_sync.sv
// sync_delay: fixed-depth shift register carrying vsync/href/de alongside the data pipeline.
module sync_delay #(
    parameter int DEPTH = 3,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] sr_q [DEPTH];
    logic [W-1:0] sr_d [DEPTH];

    // Next state: shift one position per clock, new sample enters at index 0
    always_comb begin
        sr_d[0] = din;
        for (int i = 1; i < DEPTH; i++)
            sr_d[i] = sr_q[i-1];
    end

    // Shift register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                sr_q[i] <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/rgb2ycbcr.sv
// rgb2ycbcr: 3-stage RGB888 -> YCbCr (BT.601 full range) converter with aligned sync.
// Optional build macro: RGB2YCBCR_ROUND_EN (see rgb2ycbcr_pkg). PIPE_LAT must stay 3.
module rgb2ycbcr
    import rgb2ycbcr_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              per_img_vsync,
    input  logic              per_img_href,
    input  logic              per_img_de,
    input  logic [DATA_W-1:0] per_img_red,
    input  logic [DATA_W-1:0] per_img_green,
    input  logic [DATA_W-1:0] per_img_blue,
    output logic              post_img_vsync,
    output logic              post_img_href,
    output logic              post_img_de,
    output logic [DATA_W-1:0] post_img_y,
    output logic [DATA_W-1:0] post_img_cb,
    output logic [DATA_W-1:0] post_img_cr
);

    // Product order: Y(R,G,B), Cb(R,G,B), Cr(R,G,B)
    logic [15:0] prod_d [9];
    logic [15:0] prod_q [9];
    psum_t       ys_d, cbs_d, crs_d;
    psum_t       ys_q, cbs_q, crs_q;
    pix_t        y_d, cb_d, cr_d;
    pix_t        y_q, cb_q, cr_q;

    // Stage 1: nine unsigned coefficient products
    always_comb begin
        prod_d[0] = C_Y_R  * 16'(per_img_red);
        prod_d[1] = C_Y_G  * 16'(per_img_green);
        prod_d[2] = C_Y_B  * 16'(per_img_blue);
        prod_d[3] = C_CB_R * 16'(per_img_red);
        prod_d[4] = C_CB_G * 16'(per_img_green);
        prod_d[5] = C_CB_B * 16'(per_img_blue);
        prod_d[6] = C_CR_R * 16'(per_img_red);
        prod_d[7] = C_CR_G * 16'(per_img_green);
        prod_d[8] = C_CR_B * 16'(per_img_blue);
    end

    // Stage 2: weighted sums; chroma carries the +128 offset before scaling
    always_comb begin
        ys_d  = {2'b00, prod_q[0]} + {2'b00, prod_q[1]} + {2'b00, prod_q[2]};
        cbs_d = {2'b00, prod_q[5]} - {2'b00, prod_q[3]} - {2'b00, prod_q[4]} + OFFSET_C;
        crs_d = {2'b00, prod_q[6]} - {2'b00, prod_q[7]} - {2'b00, prod_q[8]} + OFFSET_C;
    end

    // Stage 3: scale back to 8 bits and saturate
    always_comb begin
        y_d  = round_clamp(ys_q);
        cb_d = round_clamp(cbs_q);
        cr_d = round_clamp(crs_q);
    end

    // Arithmetic pipeline registers; advance every cycle regardless of de
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++)
                prod_q[i] <= '0;
            ys_q  <= '0;
            cbs_q <= '0;
            crs_q <= '0;
            y_q   <= '0;
            cb_q  <= '0;
            cr_q  <= '0;
        end else begin
            prod_q <= prod_d;
            ys_q   <= ys_d;
            cbs_q  <= cbs_d;
            crs_q  <= crs_d;
            y_q    <= y_d;
            cb_q   <= cb_d;
            cr_q   <= cr_d;
        end
    end

    sync_delay #(
        .DEPTH (PIPE_LAT),
        .W     (3)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  ({per_img_vsync, per_img_href, per_img_de}),
        .dout ({post_img_vsync, post_img_href, post_img_de})
    );

    // Blank pixel data whenever the aligned de is low
    assign post_img_y  = post_img_de ? DATA_W'(y_q)  : '0;
    assign post_img_cb = post_img_de ? DATA_W'(cb_q) : '0;
    assign post_img_cr = post_img_de ? DATA_W'(cr_q) : '0;

endmodule
